// File: rtl/fpnew_pkg.sv
// Shared FPU types: IEEE status flags and retire-buffer slot state.
package fpnew_pkg;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    typedef enum logic [1:0] {
        RETIRE_FREE    = 2'd0,
        RETIRE_PENDING = 2'd1,
        RETIRE_DONE    = 2'd2
    } retire_state_e;

    // Slot ID width; at least one bit so a Depth of 1 still has a legal port
    function automatic int unsigned retire_id_width(int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fpnew_retire_slot.sv
// One retire-buffer slot: FREE/PENDING/DONE lifecycle plus its payload registers.
module fpnew_retire_slot
    import fpnew_pkg::*;
#(
    parameter int unsigned Width   = 64,
    parameter type         TagType = logic
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          alloc_i,
    input  logic          cmpl_i,
    input  logic          free_i,
    input  TagType        tag_i,
    input  logic [Width-1:0] result_i,
    input  status_t       status_i,
    output retire_state_e state_o,
    output logic [Width-1:0] result_o,
    output status_t       status_o,
    output TagType        tag_o
);

    typedef struct packed {
        logic [Width-1:0] result;
        status_t          status;
        TagType           tag;
    } payload_t;

    retire_state_e state_q;
    payload_t      payload_q;

    // A DONE slot that is popped may be re-allocated in the same cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= RETIRE_FREE;
            payload_q <= '0;
        end else if (flush_i) begin
            state_q <= RETIRE_FREE;
        end else begin
            unique case (state_q)
                RETIRE_FREE: begin
                    if (alloc_i) begin
                        state_q       <= RETIRE_PENDING;
                        payload_q.tag <= tag_i;
                    end
                end
                RETIRE_PENDING: begin
                    if (cmpl_i) begin
                        state_q          <= RETIRE_DONE;
                        payload_q.result <= result_i;
                        payload_q.status <= status_i;
                    end
                end
                RETIRE_DONE: begin
                    if (free_i && alloc_i) begin
                        state_q       <= RETIRE_PENDING;
                        payload_q.tag <= tag_i;
                    end else if (free_i) begin
                        state_q <= RETIRE_FREE;
                    end
                end
                default: state_q <= RETIRE_FREE;
            endcase
        end
    end

    assign state_o  = state_q;
    assign result_o = payload_q.result;
    assign status_o = payload_q.status;
    assign tag_o    = payload_q.tag;

endmodule

// File: rtl/fpnew_retire_buffer.sv
// In-order retirement buffer: slots allocated at issue, filled out of order, released in issue order.
module fpnew_retire_buffer
    import fpnew_pkg::*;
#(
    parameter int unsigned NumIn   = 5,
    parameter int unsigned Width   = 64,
    parameter int unsigned Depth   = 8,
    parameter type         TagType = logic,
    localparam int unsigned IdWidth = retire_id_width(Depth)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            flush_i,
    input  logic                            issue_valid_i,
    output logic                            issue_ready_o,
    input  TagType                          issue_tag_i,
    output logic [IdWidth-1:0]              issue_id_o,
    input  logic [NumIn-1:0]                cmpl_valid_i,
    input  logic [NumIn-1:0][IdWidth-1:0]   cmpl_id_i,
    input  logic [NumIn-1:0][Width-1:0]     cmpl_result_i,
    input  status_t [NumIn-1:0]             cmpl_status_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [Width-1:0]                result_o,
    output status_t                         status_o,
    output TagType                          tag_o,
    output logic                            err_o,
    output logic                            busy_o,
    output logic [IdWidth:0]                count_o
);

    localparam int unsigned PtrWidth = IdWidth + 1;

    logic [PtrWidth-1:0] head_q, tail_q;
    logic [IdWidth-1:0]  head_id, tail_id;
    logic                full, issue_fire, pop_fire;
    logic                err_q, err_d;

    retire_state_e    slot_state  [Depth];
    logic [Width-1:0] slot_result [Depth];
    status_t          slot_status [Depth];
    TagType           slot_tag    [Depth];

    logic [Depth-1:0] alloc_en, cmpl_en, free_en;
    logic [Width-1:0] sel_result [Depth];
    status_t          sel_status [Depth];

    assign head_id    = head_q[IdWidth-1:0];
    assign tail_id    = tail_q[IdWidth-1:0];
    assign full       = (head_id == tail_id) && (head_q[IdWidth] != tail_q[IdWidth]);
    assign issue_fire = issue_valid_i && !full;
    assign pop_fire   = out_valid_o && out_ready_i;

    always_comb begin
        alloc_en = '0;
        free_en  = '0;
        if (issue_fire) alloc_en[tail_id] = 1'b1;
        if (pop_fire)   free_en[head_id]  = 1'b1;
    end

    // Per-slot priority select (lowest port wins) and illegal-completion detection
    always_comb begin
        cmpl_en = '0;
        err_d   = 1'b0;
        for (int s = 0; s < Depth; s++) begin
            sel_result[s] = '0;
            sel_status[s] = '0;
            for (int k = NumIn - 1; k >= 0; k--) begin
                if (cmpl_valid_i[k] && (cmpl_id_i[k] == IdWidth'(s))) begin
                    sel_result[s] = cmpl_result_i[k];
                    sel_status[s] = cmpl_status_i[k];
                    cmpl_en[s]    = (slot_state[s] == RETIRE_PENDING);
                end
            end
        end
        for (int k = 0; k < NumIn; k++) begin
            if (cmpl_valid_i[k]) begin
                if (slot_state[cmpl_id_i[k]] != RETIRE_PENDING) err_d = 1'b1;
                for (int j = 0; j < NumIn; j++) begin
                    if ((j < k) && cmpl_valid_i[j] && (cmpl_id_i[j] == cmpl_id_i[k])) err_d = 1'b1;
                end
            end
        end
        if (flush_i) begin
            cmpl_en = '0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= err_d;
            if (flush_i) begin
                head_q <= '0;
                tail_q <= '0;
            end else begin
                if (issue_fire) tail_q <= tail_q + PtrWidth'(1);
                if (pop_fire)   head_q <= head_q + PtrWidth'(1);
            end
        end
    end

    for (genvar s = 0; s < Depth; s++) begin : g_slot
        fpnew_retire_slot #(
            .Width   (Width),
            .TagType (TagType)
        ) i_slot (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .flush_i  (flush_i),
            .alloc_i  (alloc_en[s]),
            .cmpl_i   (cmpl_en[s]),
            .free_i   (free_en[s]),
            .tag_i    (issue_tag_i),
            .result_i (sel_result[s]),
            .status_i (sel_status[s]),
            .state_o  (slot_state[s]),
            .result_o (slot_result[s]),
            .status_o (slot_status[s]),
            .tag_o    (slot_tag[s])
        );
    end

    assign issue_ready_o = !full;
    assign issue_id_o    = tail_id;
    assign out_valid_o   = (slot_state[head_id] == RETIRE_DONE);
    assign result_o      = slot_result[head_id];
    assign status_o      = slot_status[head_id];
    assign tag_o         = slot_tag[head_id];
    assign err_o         = err_q;
    assign count_o       = tail_q - head_q;
    assign busy_o        = (count_o != '0);

endmodule

// File: tb/tb_fpnew_retire_buffer.sv
// Self-checking bench for fpnew_retire_buffer against an issue-order queue model.
module tb_fpnew_retire_buffer;
    import fpnew_pkg::*;

    localparam int unsigned NumIn = 5;
    localparam int unsigned Width = 64;
    localparam int unsigned Depth = 8;
    localparam int unsigned IdW   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush;
    logic issue_valid;
    logic issue_ready;
    logic [7:0] issue_tag;
    logic [IdW-1:0] issue_id;
    logic [NumIn-1:0] cmpl_valid;
    logic [NumIn-1:0][IdW-1:0] cmpl_id;
    logic [NumIn-1:0][Width-1:0] cmpl_result;
    status_t [NumIn-1:0] cmpl_status;
    logic out_valid;
    logic out_ready;
    logic [Width-1:0] result;
    status_t status;
    logic [7:0] tag;
    logic err;
    logic busy;
    logic [IdW:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    fpnew_retire_buffer #(
        .NumIn   (NumIn),
        .Width   (Width),
        .Depth   (Depth),
        .TagType (logic [7:0])
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .issue_valid_i (issue_valid),
        .issue_ready_o (issue_ready),
        .issue_tag_i   (issue_tag),
        .issue_id_o    (issue_id),
        .cmpl_valid_i  (cmpl_valid),
        .cmpl_id_i     (cmpl_id),
        .cmpl_result_i (cmpl_result),
        .cmpl_status_i (cmpl_status),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .result_o      (result),
        .status_o      (status),
        .tag_o         (tag),
        .err_o         (err),
        .busy_o        (busy),
        .count_o       (count)
    );

    always #5 clk = ~clk;

    // Model: outstanding instructions in issue order
    typedef struct {
        int          id;
        logic [7:0]  tg;
        logic [63:0] res;
        status_t     st;
        bit          done;
    } ent_t;

    ent_t q[$];
    int   next_id = 0;
    bit   exp_err = 0;

    task automatic idle_inputs();
        flush       = 1'b0;
        issue_valid = 1'b0;
        issue_tag   = '0;
        cmpl_valid  = '0;
        cmpl_id     = '0;
        cmpl_result = '0;
        cmpl_status = '0;
        out_ready   = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        next_id = 0;
        exp_err = 0;
    endtask

    task automatic model_step();
        int  sz0;
        bit  pop;
        int  found;
        ent_t e;
        exp_err = 0;
        if (flush) begin
            q.delete();
            next_id = 0;
            return;
        end
        sz0 = q.size();
        pop = out_ready && (sz0 > 0) && q[0].done;
        for (int k = 0; k < NumIn; k++) begin
            if (cmpl_valid[k]) begin
                found = -1;
                for (int i = 0; i < q.size(); i++)
                    if (q[i].id == int'(cmpl_id[k])) found = i;
                if (found >= 0 && !q[found].done) begin
                    q[found].done = 1;
                    q[found].res  = cmpl_result[k];
                    q[found].st   = cmpl_status[k];
                end else begin
                    exp_err = 1;
                end
            end
        end
        if (pop) void'(q.pop_front());
        if (issue_valid && sz0 < Depth) begin
            e.id = next_id; e.tg = issue_tag; e.res = '0; e.st = '0; e.done = 0;
            q.push_back(e);
            next_id = (next_id + 1) % Depth;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_n(input int n);
        for (int i = 0; i < n; i++) begin
            idle_inputs();
            issue_valid = 1'b1;
            issue_tag   = 8'(8'h40 + i);
            tick();
        end
        idle_inputs();
    endtask

    task automatic complete_one(input int port, input int id, input logic [63:0] r);
        idle_inputs();
        cmpl_valid[port]  = 1'b1;
        cmpl_id[port]     = IdW'(id);
        cmpl_result[port] = r;
        cmpl_status[port] = status_t'(5'(id + 1));
        tick();
        idle_inputs();
    endtask

    task automatic do_flush();
        idle_inputs();
        flush = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_reset();
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", issue_ready); end
        n_checks++; if (issue_id !== 3'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", issue_id); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_checks++; if (result !== 64'd0 || status !== 5'd0 || tag !== 8'd0) begin n_fail++; $display("FAIL reset_data: got %h/%h/%h want 0", result, status, tag); end
        n_checks++; if (err !== 1'b0 || busy !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL reset_flags: got err=%b busy=%b count=%0d want 0", err, busy, count); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_out_of_order();
        logic [63:0] r [3];
        for (int i = 0; i < 3; i++) r[i] = {$urandom, $urandom};
        issue_n(3);
        n_checks++; if (count !== 4'd3) begin n_fail++; $display("FAIL ooo_count: got %0d want 3", count); end
        complete_one(3, 2, r[2]);
        n_checks++; if (out_valid !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL ooo_early: got valid=%b err=%b want 0/0", out_valid, err); end
        complete_one(1, 0, r[0]);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ooo_latency: got valid=%b want 1", out_valid); end
        complete_one(0, 1, r[1]);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || result !== r[i] || tag !== 8'(8'h40 + i)) begin
                n_fail++; $display("FAIL ooo_pop%0d: got v=%b r=%h t=%h want 1/%h/%h", i, out_valid, result, tag, r[i], 8'(8'h40 + i));
            end
            tick();
        end
        n_checks++; if (count !== 4'd0 || busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_drain: got count=%0d busy=%b v=%b want 0", count, busy, out_valid); end
        idle_inputs();
    endtask

    task automatic test_full();
        do_flush();
        issue_n(8);
        n_checks++; if (issue_ready !== 1'b0 || count !== 4'd8) begin n_fail++; $display("FAIL full: got ready=%b count=%0d want 0/8", issue_ready, count); end
        complete_one(2, 0, 64'hF00D);
        issue_valid = 1'b1; issue_tag = 8'hEE; out_ready = 1'b1;
        tick();
        n_checks++; if (count !== 4'd7 || issue_ready !== 1'b1 || issue_id !== 3'd0) begin n_fail++; $display("FAIL full_pop: got count=%0d ready=%b id=%0d want 7/1/0", count, issue_ready, issue_id); end
        out_ready = 1'b0;
        tick();
        n_checks++; if (count !== 4'd8 || issue_ready !== 1'b0 || issue_id !== 3'd1) begin n_fail++; $display("FAIL full_wrap: got count=%0d ready=%b id=%0d want 8/0/1", count, issue_ready, issue_id); end
        idle_inputs();
    endtask

    task automatic test_errors();
        do_flush();
        complete_one(0, 4, 64'h1);
        n_checks++; if (err !== 1'b1 || count !== 4'd0) begin n_fail++; $display("FAIL err_free: got err=%b count=%0d want 1/0", err, count); end
        tick();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_pulse: got %b want 0", err); end
        issue_n(2);
        cmpl_valid[2] = 1'b1; cmpl_id[2] = 3'd1; cmpl_result[2] = 64'hAAAA_0002;
        cmpl_valid[4] = 1'b1; cmpl_id[4] = 3'd1; cmpl_result[4] = 64'hBBBB_0004;
        tick();
        idle_inputs();
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_dual: got %b want 1", err); end
        complete_one(0, 0, 64'h1234);
        n_checks++; if (err !== 1'b0 || out_valid !== 1'b1 || result !== 64'h1234) begin n_fail++; $display("FAIL err_head: got err=%b v=%b r=%h want 0/1/1234", err, out_valid, result); end
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b1 || result !== 64'hAAAA_0002) begin n_fail++; $display("FAIL err_lowport: got v=%b r=%h want 1/aaaa0002", out_valid, result); end
        tick();
        idle_inputs();
    endtask

    task automatic test_hold();
        logic [63:0] r0;
        status_t     s0;
        do_flush();
        issue_n(3);
        r0 = {$urandom, $urandom};
        complete_one(1, 0, r0);
        s0 = status_t'(5'd1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin cmpl_valid[1] = 1'b1; cmpl_id[1] = 3'd2; cmpl_result[1] = ~r0; cmpl_status[1] = status_t'(5'h1f); end
            tick();
            idle_inputs();
            n_checks++;
            if (out_valid !== 1'b1 || result !== r0 || status !== s0 || tag !== 8'h40 || err !== 1'b0) begin
                n_fail++; $display("FAIL hold%0d: got v=%b r=%h s=%h t=%h e=%b want 1/%h/%h/40/0", i, out_valid, result, status, tag, err, r0, s0);
            end
        end
    endtask

    task automatic test_flush();
        do_flush();
        issue_n(5);
        complete_one(0, 0, 64'h10);
        complete_one(1, 2, 64'h12);
        complete_one(2, 4, 64'h14);
        flush = 1'b1;
        cmpl_valid[0] = 1'b1; cmpl_id[0] = 3'd1; cmpl_result[0] = 64'h11;
        cmpl_valid[3] = 1'b1; cmpl_id[3] = 3'd4; cmpl_result[3] = 64'h99;
        tick();
        idle_inputs();
        n_checks++; if (count !== 4'd0 || busy !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL flush: got count=%0d busy=%b v=%b err=%b want 0", count, busy, out_valid, err); end
        tick();
        n_checks++; if (err !== 1'b0 || issue_id !== 3'd0) begin n_fail++; $display("FAIL flush_after: got err=%b id=%0d want 0/0", err, issue_id); end
        issue_n(1);
        n_checks++; if (count !== 4'd1 || issue_id !== 3'd1) begin n_fail++; $display("FAIL flush_issue: got count=%0d id=%0d want 1/1", count, issue_id); end
    endtask

    task automatic test_random();
        bit exp_valid;
        do_flush();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            idle_inputs();
            flush       = ($urandom_range(0, 149) == 0);
            issue_valid = ($urandom_range(0, 99) < 55);
            issue_tag   = 8'($urandom);
            out_ready   = ($urandom_range(0, 99) < 60);
            for (int k = 0; k < NumIn; k++) begin
                if ($urandom_range(0, 99) < 20) begin
                    cmpl_valid[k]  = 1'b1;
                    cmpl_result[k] = {$urandom, $urandom};
                    cmpl_status[k] = status_t'(5'($urandom));
                    if (q.size() > 0 && $urandom_range(0, 99) < 90)
                        cmpl_id[k] = IdW'(q[$urandom_range(0, q.size() - 1)].id);
                    else
                        cmpl_id[k] = IdW'($urandom);
                end
            end
            tick();
            exp_valid = (q.size() > 0) && q[0].done;
            n_checks++; if (out_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, out_valid, exp_valid); end
            if (exp_valid) begin
                n_checks++;
                if (result !== q[0].res || status !== q[0].st || tag !== q[0].tg) begin
                    n_fail++; $display("FAIL rnd_data@%0d: got %h/%h/%h want %h/%h/%h", cyc, result, status, tag, q[0].res, q[0].st, q[0].tg);
                end
            end
            n_checks++; if (count !== 4'(q.size()) || busy !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_count@%0d: got %0d/%b want %0d", cyc, count, busy, q.size()); end
            n_checks++; if (issue_ready !== (q.size() < Depth) || issue_id !== IdW'(next_id)) begin n_fail++; $display("FAIL rnd_issue@%0d: got %b/%0d want %b/%0d", cyc, issue_ready, issue_id, q.size() < Depth, next_id); end
            n_checks++; if (err !== exp_err) begin n_fail++; $display("FAIL rnd_err@%0d: got %b want %b", cyc, err, exp_err); end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_flush();
        issue_n(6);
        complete_one(0, 0, 64'h77);
        complete_one(1, 3, 64'h33);
        cmpl_valid[0] = 1'b1; cmpl_id[0] = 3'd0; cmpl_result[0] = 64'h1;
        rst = 1'b1;
        #1;
        n_checks++; if (issue_ready !== 1'b1 || issue_id !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctl: got ready=%b id=%0d v=%b want 1/0/0", issue_ready, issue_id, out_valid); end
        n_checks++; if (result !== 64'd0 || status !== 5'd0 || tag !== 8'd0) begin n_fail++; $display("FAIL rstmid_data: got %h/%h/%h want 0", result, status, tag); end
        n_checks++; if (err !== 1'b0 || busy !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL rstmid_flags: got err=%b busy=%b count=%0d want 0", err, busy, count); end
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_out_of_order();
        test_full();
        test_errors();
        test_hold();
        test_flush();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
